// File: rtl/pong_pkg.sv
// Shared constants, FSM state type and position helpers
// for the pong paddle scheduler.
package pong_pkg;

  localparam int POS_W      = 32;
  localparam int PADDLE_LEN = 8;
  localparam int ROW_W      = 5;
  localparam int LO_W       = $clog2(POS_W);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FREEZE   = 2'd1,
    ST_RECENTER = 2'd2
  } state_e;

  function automatic logic [LO_W-1:0] low_bit(
    input logic [POS_W-1:0] pos
  );
    logic [LO_W-1:0] lo;
    lo = '0;
    for (int i = POS_W - 1; i >= 0; i--) begin
      if (pos[i]) lo = LO_W'(i);
    end
    return lo;
  endfunction

endpackage

// File: rtl/paddle_sched_if.sv
// Game-side bundle: player/ball/score inputs and
// paddle move/recenter outputs of the scheduler.
interface paddle_sched_if;
  import pong_pkg::*;

  logic             btn_l_up;
  logic             btn_l_dn;
  logic             btn_r_up;
  logic             btn_r_dn;
  logic             cpu_en;
  logic [ROW_W-1:0] ball_row;
  logic             point_scored;
  logic [POS_W-1:0] pos_l;
  logic [POS_W-1:0] pos_r;
  logic             l_up;
  logic             l_dn;
  logic             r_up;
  logic             r_dn;
  logic             paddle_rst_n;
  logic             frozen;

  modport master (
    output btn_l_up, btn_l_dn,
    output btn_r_up, btn_r_dn,
    output cpu_en, ball_row,
    output point_scored,
    output pos_l, pos_r,
    input  l_up, l_dn, r_up, r_dn,
    input  paddle_rst_n, frozen
  );

  modport slave (
    input  btn_l_up, btn_l_dn,
    input  btn_r_up, btn_r_dn,
    input  cpu_en, ball_row,
    input  point_scored,
    input  pos_l, pos_r,
    output l_up, l_dn, r_up, r_dn,
    output paddle_rst_n, frozen
  );

endinterface

// File: rtl/paddle_sched_move_gate.sv
// Per-paddle move gate: turns an up/down request into a
// registered one-cycle pulse at a tick, blocked at the rails.
module move_gate
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_up,
  input  logic             i_dn,
  input  logic             i_tick,
  input  logic [POS_W-1:0] i_pos,
  output logic             o_up,
  output logic             o_dn
);

  logic w_up;
  logic w_dn;
  logic w_unused_pos;
  logic r_up;
  logic r_dn;

  // only the rail bits matter; the body of the paddle is ignored
  assign w_unused_pos = ^i_pos[POS_W-2:1];

  assign w_up = i_tick & i_up & ~i_dn
              & ~i_pos[POS_W-1];
  assign w_dn = i_tick & i_dn & ~i_up
              & ~i_pos[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_up <= 1'b0;
      r_dn <= 1'b0;
    end else begin
      r_up <= w_up;
      r_dn <= w_dn;
    end
  end

  assign o_up = r_up;
  assign o_dn = r_dn;

endmodule

// File: rtl/paddle_sched.sv
// Paddle scheduler: paces paddle steps, drives the CPU paddle
// and freezes/recenters both paddles after each point.
module paddle_sched
  import pong_pkg::*;
#(
  parameter int MOVE_PERIOD   = 4,
  parameter int FREEZE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  paddle_sched_if.slave bus
);

  localparam logic [7:0] TICK_MAX = 8'(MOVE_PERIOD - 1);
  localparam logic [7:0] FRZ_LOAD = 8'(FREEZE_CYCLES - 1);
  localparam logic [LO_W:0] CPU_HI =
    (LO_W + 1)'(PADDLE_LEN / 2);
  localparam logic [LO_W:0] CPU_LO =
    (LO_W + 1)'(PADDLE_LEN / 2 - 1);

  state_e r_state;
  state_e w_next;

  logic [7:0] r_tick;
  logic [7:0] r_frz;
  logic       r_frozen;
  logic       r_prst;

  logic w_tick;
  logic w_move_en;
  logic w_frozen_d;
  logic w_prst_d;

  logic [LO_W-1:0] w_lo;
  logic [LO_W:0]   w_lo_x;
  logic [LO_W:0]   w_row;
  logic            w_cpu_up;
  logic            w_cpu_dn;
  logic            w_r_up_req;
  logic            w_r_dn_req;

  logic w_l_up;
  logic w_l_dn;
  logic w_r_up;
  logic w_r_dn;

  assign w_tick = (r_state == ST_RUN)
                & (r_tick == TICK_MAX);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RUN:
        if (bus.point_scored) w_next = ST_FREEZE;
      ST_FREEZE:
        if (r_frz == '0) w_next = ST_RECENTER;
      ST_RECENTER:
        w_next = ST_RUN;
      default:
        w_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_move_en  = 1'b0;
    w_frozen_d = 1'b0;
    w_prst_d   = 1'b1;
    unique case (r_state)
      ST_RUN: begin
        w_move_en  = w_tick & ~bus.point_scored;
        w_frozen_d = bus.point_scored;
      end
      ST_FREEZE:   w_frozen_d = 1'b1;
      ST_RECENTER: w_prst_d   = 1'b0;
      default: ;
    endcase
  end

  // tick count restarts from zero on every entry to RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tick   <= '0;
      r_frz    <= '0;
      r_frozen <= 1'b0;
      r_prst   <= 1'b0;
    end else begin
      r_frozen <= w_frozen_d;
      r_prst   <= w_prst_d;
      if (r_state != ST_RUN) r_tick <= '0;
      else if (w_tick)       r_tick <= '0;
      else                   r_tick <= r_tick + 8'd1;
      if (r_state == ST_RUN && bus.point_scored)
        r_frz <= FRZ_LOAD;
      else if (r_state == ST_FREEZE && r_frz != '0)
        r_frz <= r_frz - 8'd1;
    end
  end

  assign w_lo   = low_bit(bus.pos_r);
  assign w_lo_x = {1'b0, w_lo};
  assign w_row  = {1'b0, bus.ball_row};

  assign w_cpu_up = w_row > (w_lo_x + CPU_HI);
  assign w_cpu_dn = w_row < (w_lo_x + CPU_LO);

  assign w_r_up_req = bus.cpu_en ? w_cpu_up
                                 : bus.btn_r_up;
  assign w_r_dn_req = bus.cpu_en ? w_cpu_dn
                                 : bus.btn_r_dn;

  move_gate u_gate_l (
    .clk    (clk),
    .reset  (reset),
    .i_up   (bus.btn_l_up),
    .i_dn   (bus.btn_l_dn),
    .i_tick (w_move_en),
    .i_pos  (bus.pos_l),
    .o_up   (w_l_up),
    .o_dn   (w_l_dn)
  );

  move_gate u_gate_r (
    .clk    (clk),
    .reset  (reset),
    .i_up   (w_r_up_req),
    .i_dn   (w_r_dn_req),
    .i_tick (w_move_en),
    .i_pos  (bus.pos_r),
    .o_up   (w_r_up),
    .o_dn   (w_r_dn)
  );

  assign bus.l_up         = w_l_up;
  assign bus.l_dn         = w_l_dn;
  assign bus.r_up         = w_r_up;
  assign bus.r_dn         = w_r_dn;
  assign bus.frozen       = r_frozen;
  assign bus.paddle_rst_n = r_prst;

endmodule

// File: doc/paddle_sched.md
PADDLE_SCHED -- requirements
Module: paddle_sched

Interface
REQ-001 Parameter MOVE_PERIOD, default 4: clock cycles between permitted paddle steps (legal range 2..255).
REQ-002 Parameter FREEZE_CYCLES, default 16: cycles paddles are held after a point (legal range 1..255).
REQ-003 Port clk  input  1  rising-edge clock, single clock domain.
REQ-004 Port reset  input  1  active-low synchronous reset, sampled on the rising edge of clk.
REQ-005 Port btn_l_up, btn_l_dn  input  1 each  left player requests, level-sensitive.
REQ-006 Port btn_r_up, btn_r_dn  input  1 each  right player requests, level-sensitive.
REQ-007 Port cpu_en  input  1  when 1, the right paddle is driven by ball tracking and the right buttons are ignored.
REQ-008 Port ball_row  input  5  ball vertical row 0..31.
REQ-009 Port point_scored  input  1  one-cycle pulse from the game logic.
REQ-010 Port pos_l, pos_r  input  32 each  paddle position vectors; 8 contiguous ones; bit 31 is the top.
REQ-011 Port l_up, l_dn, r_up, r_dn  output  1 each  registered move pulses to the paddles.
REQ-012 Port paddle_rst_n  output  1  registered active-low recenter strobe to both paddles.
REQ-013 Port frozen  output  1  registered; 1 while in FREEZE or RECENTER.

Function
REQ-014 The block SHALL implement an FSM with states RUN, FREEZE and RECENTER.
REQ-015 In RUN, a tick counter SHALL count 0..MOVE_PERIOD-1 and wrap; tick is asserted when count == MOVE_PERIOD-1.
REQ-016 Move outputs SHALL pulse high for exactly one cycle, in the cycle after a tick, and SHALL be 0 at all other times.
REQ-017 Per paddle, a request with only up asserted SHALL yield an up pulse, with only down asserted SHALL yield a down pulse, and with both or neither asserted SHALL yield no pulse.
REQ-018 An up pulse SHALL be suppressed when pos[31] = 1, and a down pulse SHALL be suppressed when pos[0] = 1 (evaluated at the tick).
REQ-019 Up and down pulses for the same paddle SHALL never be asserted together.
REQ-020 In CPU mode, let lo be the index of the lowest set bit of pos_r: if ball_row > lo+4 the request is up; if ball_row < lo+3 it is down; otherwise there is no request.
REQ-021 cpu_en SHALL be sampled at each tick only, so a mode change takes effect at the next tick.
REQ-022 In RUN, point_scored = 1 SHALL cause a transition to FREEZE, load the freeze counter with FREEZE_CYCLES-1, and suppress any move pulse due in that cycle.
REQ-023 FREEZE SHALL decrement the freeze counter each cycle and transition to RECENTER when it reaches 0; no move pulses are issued in FREEZE.
REQ-024 RECENTER SHALL last exactly one cycle, with paddle_rst_n = 0 in the following cycle, and then transition to RUN with the tick counter cleared to 0.
REQ-025 point_scored asserted in FREEZE or RECENTER SHALL be ignored.
REQ-026 The freeze counter SHALL be 8 bits wide; the tick counter SHALL be 8 bits wide; no arithmetic shall overflow for legal parameter values.

Reset
REQ-027 While reset = 0 at a clock edge, the next state SHALL be: state RUN, both counters 0, all move outputs 0, frozen = 0, paddle_rst_n = 0.
REQ-028 paddle_rst_n SHALL return to 1 on the first edge with reset = 1; reset asserted mid-FREEZE SHALL abort the freeze with no additional RECENTER strobe.

Structure
REQ-029 Package pong_pkg SHALL hold POS_W = 32, PADDLE_LEN = 8, ROW_W = 5 and the FSM state enum.
REQ-030 Sub-module move_gate SHALL be instantiated once per paddle: it takes the up/down request, the tick and the position vector, and produces the registered up/down pulses.
REQ-031 The lowest-set-bit encoder for pos_r SHALL be a function in pong_pkg.

Verification
REQ-032 Reset release, MOVE_PERIOD = 4, btn_l_up held, pos_l = 0x000FF000 -> l_up pulses at cycles 4, 8, 12 after reset release, and l_dn stays 0.
REQ-033 pos_l = 0xFF000000 with btn_l_up held -> l_up stays 0; with btn_l_up and btn_l_dn both held -> neither pulse fires.
REQ-034 cpu_en = 1, pos_r = 0x000FF000 (lo = 12), ball_row = 20 -> r_up each tick; ball_row = 15 -> no pulse; ball_row = 5 -> r_dn each tick.
REQ-035 point_scored coincident with a tick, FREEZE_CYCLES = 16 -> no pulse, frozen = 1 for 17 cycles, paddle_rst_n = 0 for one cycle, first post-freeze pulse 4 cycles later.
REQ-036 reset driven low during cycle 5 of FREEZE -> next cycle frozen = 0, paddle_rst_n = 0, and no later duplicate strobe.
REQ-037 A second point_scored during FREEZE -> freeze length unchanged at 16+1 cycles.
